// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// FSM state encoding and the reset instruction word.
package fetch_unit_pkg;

  // Next-PC select encodings driven by the controller
  localparam logic [1:0] PCSRC_PLUS4     = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH    = 2'b01;
  localparam logic [1:0] PCSRC_JALR      = 2'b10;
  localparam logic [1:0] PCSRC_PLUS4_ALT = 2'b11;

  // addi x0, x0, 0 -- the instruction register holds this out of reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    ERR   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and the memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Combinational next-PC selection: sequential, PC-relative branch/jal, or jalr.
module next_pc_mux
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic [1:0]  pc_src,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  // All sums wrap modulo 2^32; jalr clears bit 0 of the ALU target
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    case (pc_src)
      PCSRC_PLUS4:     next_pc = pc_plus4;
      PCSRC_BRANCH:    next_pc = pc + imm_ext;
      PCSRC_JALR:      next_pc = alu_result & 32'hFFFF_FFFE;
      PCSRC_PLUS4_ALT: next_pc = pc_plus4;
      default:         next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at PC, waits for the memory with a
// timeout, holds the instruction until the core advances, then steps the PC.
// Optional macro FETCH_MISALIGN_CHK_EN traps misaligned next-PC targets
// instead of silently clearing the low address bits.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
)
(
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic [1:0]   PCSrc,
  input  logic [31:0]  ImmExt,
  input  logic [31:0]  ALUResult,
  input  logic         advance,
  output logic         instr_valid,
  output logic [31:0]  Instr,
  output logic [6:0]   op,
  output logic [2:0]   func3,
  output logic [6:0]   func7,
  output logic [31:0]  PC,
  output logic [31:0]  PCPlus4,
  output logic         fetch_err
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic         misalign
`endif
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  fetch_state_t state_q, state_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc_raw;
`ifdef FETCH_MISALIGN_CHK_EN
  logic         misalign_q, misalign_d;
`endif

  next_pc_mux u_next_pc_mux (
    .pc         (pc_q),
    .imm_ext    (ImmExt),
    .alu_result (ALUResult),
    .pc_src     (PCSrc),
    .next_pc    (next_pc_raw),
    .pc_plus4   (PCPlus4)
  );

  // Next-state logic: memory handshake with timeout, then hold until advance
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d    = imem.imem_rdata;
          wait_cnt_d = '0;
          state_d    = VALID;
        end else if (wait_cnt_q == LAST_WAIT) begin
          wait_cnt_d = '0;
          state_d    = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      VALID: begin
        if (advance) begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (next_pc_raw[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ERR;
          end else begin
            pc_d    = next_pc_raw;
            state_d = FETCH;
          end
`else
          pc_d    = next_pc_raw & 32'hFFFF_FFFC;
          state_d = FETCH;
`endif
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: state_d = FETCH;
    endcase
  end

  // State register with synchronous reset; reset discards any fetch in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Request is held off while reset is asserted so a new fetch starts after release
  assign imem.imem_req  = (state_q == FETCH) && !rst;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == VALID);
  assign fetch_err      = (state_q == ERR);
  assign Instr          = instr_q;
  assign op             = instr_q[6:0];
  assign func3          = instr_q[14:12];
  assign func7          = instr_q[31:25];
  assign PC             = pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign       = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard testbench for fetch_unit. Stimulus pushes expected request
// addresses, fetched instructions and error events into queues; a monitor
// pops and compares them when the DUT presents the matching event.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        advance;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_err;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .PCSrc       (PCSrc),
    .ImmExt      (ImmExt),
    .ALUResult   (ALUResult),
    .advance     (advance),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .fetch_err   (fetch_err)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign    (misalign)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } fetch_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } err_exp_t;

  logic [31:0] addr_q[$];
  fetch_exp_t  fetch_q[$];
  err_exp_t    err_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [31:0] rdata, input logic [1:0] src,
                               input logic [31:0] imm, input logic [31:0] alu, input logic adv);
    imem_bus.imem_ready = ready;
    imem_bus.imem_rdata = rdata;
    PCSrc     = src;
    ImmExt    = imm;
    ALUResult = alu;
    advance   = adv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    fetch_q.push_back('{pc, instr, o, f3, f7});
  endtask

  // Hold imem_ready low through the whole timeout window, then show late data is ignored
  task automatic run_timeout(input logic [31:0] exp_pc);
    err_q.push_back('{exp_pc, 1'b0});
    idle(15);
    checkOutput("pre_timeout_err", {31'b0, fetch_err}, 32'd0);
    idle(1);
    checkOutput("timeout_err", {31'b0, fetch_err}, 32'd1);
    checkOutput("timeout_req", {31'b0, imem_bus.imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b01, 32'h40, 32'h0, 1'b1);
    checkOutput("late_ready_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("late_ready_err", {31'b0, fetch_err}, 32'd1);
  endtask

  // Monitor: on the falling edge, compare each new request, fetch and error event
  logic       prev_req = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;
  fetch_exp_t mon_fe;
  err_exp_t   mon_ee;
  logic [31:0] mon_addr;
  always @(negedge clk) begin
    if (imem_bus.imem_req === 1'b1 && !prev_req) begin
      if (addr_q.size() == 0) checkOutput("unexpected_req", imem_bus.imem_addr, 32'hxxxx_xxxx);
      else begin
        mon_addr = addr_q.pop_front();
        checkOutput("req_addr", imem_bus.imem_addr, mon_addr);
      end
    end
    if (instr_valid === 1'b1 && !prev_valid) begin
      if (fetch_q.size() == 0) checkOutput("unexpected_valid", Instr, 32'hxxxx_xxxx);
      else begin
        mon_fe = fetch_q.pop_front();
        checkOutput("fetch_instr", Instr, mon_fe.instr);
        checkOutput("fetch_pc", PC, mon_fe.pc);
        checkOutput("fetch_op", {25'b0, op}, {25'b0, mon_fe.op});
        checkOutput("fetch_func3", {29'b0, func3}, {29'b0, mon_fe.f3});
        checkOutput("fetch_func7", {25'b0, func7}, {25'b0, mon_fe.f7});
      end
    end
    if (fetch_err === 1'b1 && !prev_err) begin
      if (err_q.size() == 0) checkOutput("unexpected_err", PC, 32'hxxxx_xxxx);
      else begin
        mon_ee = err_q.pop_front();
        checkOutput("err_pc", PC, mon_ee.pc);
        checkOutput("err_req", {31'b0, imem_bus.imem_req}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        checkOutput("err_misalign", {31'b0, misalign}, {31'b0, mon_ee.mis});
`endif
      end
    end
    prev_req   = (imem_bus.imem_req === 1'b1);
    prev_valid = (instr_valid === 1'b1);
    prev_err   = (fetch_err === 1'b1);
  end

  // Directed stimulus sequence
  initial begin
    rst = 1'b1;
    idle(3);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_err", {31'b0, fetch_err}, 32'd0);
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_instr", Instr, NOP_INSTR);
    checkOutput("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    checkOutput("rst_pcplus4", PCPlus4, 32'h4);

    // First fetch: ready on the third request cycle; advance during FETCH is ignored
    addr_q.push_back(32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 2'b01, 32'h40, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 2'b01, 32'h40, 32'h0, 1'b1);
    expect_fetch(32'h0, 32'h0050_0093, 7'b0010011, 3'b000, 7'b0000000);
    applyStimulus(1'b1, 32'h0050_0093, 2'b00, 32'h0, 32'h0, 1'b0);
    checkOutput("valid_after_ready", {31'b0, instr_valid}, 32'd1);
    idle(1);
    checkOutput("hold_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("hold_pc", PC, 32'h0);
    checkOutput("hold_req", {31'b0, imem_bus.imem_req}, 32'd0);

    // Branch forward to 0x10
    addr_q.push_back(32'h10);
    applyStimulus(1'b0, 32'h0, 2'b01, 32'h10, 32'h0, 1'b1);
    expect_fetch(32'h10, 32'hFFF0_F093, 7'b0010011, 3'b111, 7'b1111111);
    applyStimulus(1'b1, 32'hFFF0_F093, 2'b00, 32'h0, 32'h0, 1'b0);

    // Backward branch: 0x10 + (-8) = 0x08
    addr_q.push_back(32'h08);
    applyStimulus(1'b0, 32'h0, 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b1);
    expect_fetch(32'h08, 32'h40B5_0533, 7'b0110011, 3'b000, 7'b0100000);
    idle(1);
    applyStimulus(1'b1, 32'h40B5_0533, 2'b00, 32'h0, 32'h0, 1'b0);

    // PCSrc=11 behaves as PC+4
    addr_q.push_back(32'h0C);
    applyStimulus(1'b0, 32'h0, 2'b11, 32'h100, 32'h200, 1'b1);
    expect_fetch(32'h0C, 32'h0000_0013, 7'b0010011, 3'b000, 7'b0000000);
    applyStimulus(1'b1, 32'h0000_0013, 2'b00, 32'h0, 32'h0, 1'b0);

    // jalr to 0xFFFFFFFD clears bit 0 -> 0xFFFFFFFC
    addr_q.push_back(32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 2'b10, 32'h0, 32'hFFFF_FFFD, 1'b1);
    expect_fetch(32'hFFFF_FFFC, 32'h00A0_0113, 7'b0010011, 3'b000, 7'b0000000);
    applyStimulus(1'b1, 32'h00A0_0113, 2'b00, 32'h0, 32'h0, 1'b0);
    checkOutput("wrap_pcplus4", PCPlus4, 32'h0);

    // PC+4 at the top of the address space wraps to 0
    addr_q.push_back(32'h0);
    applyStimulus(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1);
    expect_fetch(32'h0, 32'h0050_0093, 7'b0010011, 3'b000, 7'b0000000);
    applyStimulus(1'b1, 32'h0050_0093, 2'b00, 32'h0, 32'h0, 1'b0);
    addr_q.push_back(32'h20);
    applyStimulus(1'b0, 32'h0, 2'b01, 32'h20, 32'h0, 1'b1);
    expect_fetch(32'h20, 32'h40B5_0533, 7'b0110011, 3'b000, 7'b0100000);
    applyStimulus(1'b1, 32'h40B5_0533, 2'b00, 32'h0, 32'h0, 1'b0);

    // Reset in VALID while advance is high
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'b01, 32'h40, 32'h0, 1'b1);
    checkOutput("midrst_pc", PC, 32'h0);
    checkOutput("midrst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midrst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    checkOutput("midrst_instr", Instr, NOP_INSTR);
    addr_q.push_back(32'h0);
    rst = 1'b0;

    // Ready on the last cycle of the timeout window wins over the timeout
    idle(15);
    checkOutput("edge_wait_valid", {31'b0, instr_valid}, 32'd0);
    expect_fetch(32'h0, 32'h0050_0093, 7'b0010011, 3'b000, 7'b0000000);
    applyStimulus(1'b1, 32'h0050_0093, 2'b00, 32'h0, 32'h0, 1'b0);
    checkOutput("edge_ready_err", {31'b0, fetch_err}, 32'd0);

    // jalr to 0x103: target 0x102 is misaligned
`ifdef FETCH_MISALIGN_CHK_EN
    err_q.push_back('{32'h0, 1'b1});
    applyStimulus(1'b0, 32'h0, 2'b10, 32'h0, 32'h103, 1'b1);
    checkOutput("mis_flag", {31'b0, misalign}, 32'd1);
    checkOutput("mis_pc", PC, 32'h0);
    checkOutput("mis_valid", {31'b0, instr_valid}, 32'd0);
    rst = 1'b1;
    idle(1);
    checkOutput("mis_rst_clear", {31'b0, misalign}, 32'd0);
    addr_q.push_back(32'h0);
    rst = 1'b0;
    run_timeout(32'h0);
`else
    addr_q.push_back(32'h100);
    applyStimulus(1'b0, 32'h0, 2'b10, 32'h0, 32'h103, 1'b1);
    run_timeout(32'h100);
`endif

    idle(2);
    checkOutput("addr_q_drained", addr_q.size(), 32'd0);
    checkOutput("fetch_q_drained", fetch_q.size(), 32'd0);
    checkOutput("err_q_drained", err_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
